// File: rtl/sram_macro_ctrl_if.sv
// Request/response handshake bundle between a client and sram_macro_ctrl.
// Master drives requests and consumes responses; slave is the controller.
interface sram_macro_ctrl_if #(
    parameter int Bits      = 512,
    parameter int Add_Width = 5
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic [Add_Width-1:0] req_addr;
    logic [Bits-1:0]      req_wdata;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [Bits-1:0]      resp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/sram_macro_ctrl.sv
// Single-port SRAM macro front end: post-reset clear sweep, request
// strobing, one-cycle Q capture and a 2-entry in-order response buffer.
module sram_macro_ctrl #(
    parameter int Bits       = 512,
    parameter int Word_Depth = 32,
    parameter int Add_Width  = 5
) (
    input  logic                 CLK,
    input  logic                 RSTB,
    sram_macro_ctrl_if.slave     bus,
    output logic                 init_done,
    output logic                 mem_CEB,
    output logic                 mem_WEB,
    output logic [Add_Width-1:0] mem_A,
    output logic [Bits-1:0]      mem_D,
    input  logic [Bits-1:0]      mem_Q
);
    localparam logic [0:0] INIT = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;
    localparam logic [Add_Width-1:0] LAST = Add_Width'(Word_Depth - 1);

    logic [0:0]           state;
    logic [Add_Width-1:0] cnt;
    logic [1:0]           occ;
    logic                 rd_inflight;
    logic                 head;
    logic                 tail;
    logic [Bits-1:0]      fifo [2];
    logic                 push;
    logic                 pop;
    logic                 acc;
    logic [2:0]           credit;

    assign bus.resp_valid = (occ != 2'd0);
    assign bus.resp_rdata = fifo[head];
    assign init_done      = (state == RUN);

    assign pop    = bus.resp_valid && bus.resp_ready;
    assign push   = rd_inflight;
    // Slots already claimed once this cycle's pop has freed its entry.
    assign credit = {1'b0, occ} + {2'b0, rd_inflight} - {2'b0, pop};

    assign bus.req_ready = RSTB && (state == RUN) && (credit < 3'd2);
    assign acc           = bus.req_valid && bus.req_ready;

    always_comb begin
        mem_CEB = 1'b1;
        mem_WEB = 1'b1;
        mem_A   = '0;
        mem_D   = '0;
        if (!RSTB) begin
            mem_CEB = 1'b1;
        end else if (state == INIT) begin
            mem_CEB = 1'b0;
            mem_WEB = 1'b0;
            mem_A   = cnt;
        end else if (acc) begin
            mem_CEB = 1'b0;
            mem_WEB = ~bus.req_write;
            mem_A   = bus.req_addr;
            mem_D   = bus.req_write ? bus.req_wdata : '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTB) begin
            state       <= INIT;
            cnt         <= '0;
            occ         <= '0;
            rd_inflight <= 1'b0;
            head        <= 1'b0;
            tail        <= 1'b0;
            fifo[0]     <= '0;
            fifo[1]     <= '0;
        end else begin
            if (state == INIT) begin
                cnt <= cnt + Add_Width'(1);
                if (cnt == LAST) begin
                    state <= RUN;
                end
            end
            rd_inflight <= acc && !bus.req_write;
            // Q is only meaningful on the cycle after a read strobe.
            if (push) begin
                fifo[tail] <= mem_Q;
                tail       <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule
